// File: rtl/pass_scheduler.sv
// rtl/pass_scheduler.sv - loads the grid into the solver core and runs passes until the grid is stable
module pass_scheduler #(
    parameter int GRID_CELLS = 100,
    parameter int ADDR_W     = 7,
    parameter int REM_W      = 16,
    parameter int TOTAL_W    = 24,
    parameter int PASS_W     = 8,
    parameter int MAX_PASSES = 255,
    parameter int TIMEOUT    = 1023
) (
    input  logic               clock_i,
    input  logic               clear_n_i,
    input  logic               go_i,
    input  logic               load_valid_i,
    input  logic               load_data_i,
    output logic               load_ready_o,
    output logic               solver_clear_o,
    output logic               solver_start_o,
    output logic               solver_write_enable_o,
    output logic [ADDR_W-1:0]  solver_write_address_o,
    output logic               solver_write_data_o,
    input  logic               solver_done_i,
    input  logic [REM_W-1:0]   solver_removed_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [TOTAL_W-1:0] grand_total_o,
    output logic [PASS_W-1:0]  pass_count_o,
    output logic               limit_hit_o,
    output logic               timeout_o
);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam int SUM_W  = TOTAL_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(GRID_CELLS - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);
    localparam logic [PASS_W-1:0] PASS_MAX  = PASS_W'(MAX_PASSES);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CLEAR, S_START, S_WAIT, S_ACCUM, S_FINISH
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [REM_W-1:0]    cap_q, cap_d;
    logic [TOTAL_W-1:0]  total_q, total_d;
    logic [PASS_W-1:0]   pass_q, pass_d;
    logic                limit_q, limit_d;
    logic                timeout_q, timeout_d;
    logic [SUM_W-1:0]    sum;
    logic [PASS_W-1:0]   pass_inc;

    always_ff @(posedge clock_i or negedge clear_n_i) begin
        if (!clear_n_i) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wait_q    <= '0;
            cap_q     <= '0;
            total_q   <= '0;
            pass_q    <= '0;
            limit_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wait_q    <= wait_d;
            cap_q     <= cap_d;
            total_q   <= total_d;
            pass_q    <= pass_d;
            limit_q   <= limit_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wait_d    = wait_q;
        cap_d     = cap_q;
        total_d   = total_q;
        pass_d    = pass_q;
        limit_d   = limit_q;
        timeout_d = timeout_q;
        sum       = {1'b0, total_q} + SUM_W'(cap_q);
        pass_inc  = (pass_q == '1) ? pass_q : pass_q + 1'b1;
        case (state_q)
            S_IDLE, S_FINISH: begin
                if (go_i) begin
                    addr_d    = '0;
                    total_d   = '0;
                    pass_d    = '0;
                    limit_d   = 1'b0;
                    timeout_d = 1'b0;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                if (load_valid_i) begin
                    addr_d = addr_q + 1'b1;
                    if (addr_q == LAST_ADDR) state_d = S_CLEAR;
                end
            end
            S_CLEAR: state_d = S_START;
            S_START: begin
                wait_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // done takes priority over an expiring timeout in the same cycle
                wait_d = wait_q + 1'b1;
                if (solver_done_i) begin
                    cap_d   = solver_removed_i;
                    state_d = S_ACCUM;
                end else if (wait_d == WAIT_MAX) begin
                    timeout_d = 1'b1;
                    state_d   = S_FINISH;
                end
            end
            S_ACCUM: begin
                total_d = sum[TOTAL_W] ? '1 : sum[TOTAL_W-1:0];
                pass_d  = pass_inc;
                if (cap_q == '0) begin
                    state_d = S_FINISH;
                end else if (pass_inc == PASS_MAX) begin
                    limit_d = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    state_d = S_CLEAR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign load_ready_o           = (state_q == S_LOAD);
    assign solver_clear_o         = (state_q == S_IDLE) || (state_q == S_LOAD) ||
                                    (state_q == S_CLEAR) || (state_q == S_FINISH);
    assign solver_start_o         = (state_q == S_START);
    assign solver_write_enable_o  = load_valid_i & load_ready_o;
    assign solver_write_address_o = addr_q;
    assign solver_write_data_o    = load_data_i;
    assign busy_o                 = (state_q != S_IDLE) && (state_q != S_FINISH);
    assign done_o                 = (state_q == S_FINISH);
    assign grand_total_o          = total_q;
    assign pass_count_o           = pass_q;
    assign limit_hit_o            = limit_q;
    assign timeout_o              = timeout_q;
endmodule

// File: tb/tb_pass_scheduler.sv
// tb/tb_pass_scheduler.sv - directed bench with a roll-removal solver stub shared by two scheduler builds
module tb_pass_scheduler;
    localparam int TMO = 1023;

    logic clk = 1'b0;
    logic rst_n, go1, go2, lv, ld;
    always #5 clk = ~clk;

    logic        rdy1, clr1, st1, we1, wd1, busy1, done1, lim1, tmo1;
    logic [6:0]  addr1;
    logic [23:0] tot1;
    logic [7:0]  pc1;
    logic        rdy2, clr2, st2, we2, wd2, busy2, done2, lim2, tmo2;
    logic [6:0]  addr2;
    logic [23:0] tot2;
    logic [7:0]  pc2;
    logic        sdone;
    logic [15:0] srem;

    pass_scheduler dut (
        .clock_i(clk), .clear_n_i(rst_n), .go_i(go1), .load_valid_i(lv), .load_data_i(ld),
        .load_ready_o(rdy1), .solver_clear_o(clr1), .solver_start_o(st1),
        .solver_write_enable_o(we1), .solver_write_address_o(addr1), .solver_write_data_o(wd1),
        .solver_done_i(sdone), .solver_removed_i(srem), .busy_o(busy1), .done_o(done1),
        .grand_total_o(tot1), .pass_count_o(pc1), .limit_hit_o(lim1), .timeout_o(tmo1));

    pass_scheduler #(.MAX_PASSES(1)) dut_lim (
        .clock_i(clk), .clear_n_i(rst_n), .go_i(go2), .load_valid_i(lv), .load_data_i(ld),
        .load_ready_o(rdy2), .solver_clear_o(clr2), .solver_start_o(st2),
        .solver_write_enable_o(we2), .solver_write_address_o(addr2), .solver_write_data_o(wd2),
        .solver_done_i(sdone), .solver_removed_i(srem), .busy_o(busy2), .done_o(done2),
        .grand_total_o(tot2), .pass_count_o(pc2), .limit_hit_o(lim2), .timeout_o(tmo2));

    // Solver stub: owns the cell memory, removes every roll with fewer than 4 neighbours per pass
    bit          sel = 1'b0;
    bit          hang = 1'b0;
    logic [99:0] grid;
    int          lat = 0;
    logic        s_we, s_wd, s_clr, s_st;
    logic [6:0]  s_addr;
    assign s_we   = sel ? we2 : we1;
    assign s_wd   = sel ? wd2 : wd1;
    assign s_clr  = sel ? clr2 : clr1;
    assign s_st   = sel ? st2 : st1;
    assign s_addr = sel ? addr2 : addr1;

    function automatic logic [99:0] removable(input logic [99:0] g);
        logic [99:0] m = '0;
        for (int r = 0; r < 10; r++) begin
            for (int c = 0; c < 10; c++) begin
                if (g[r*10+c]) begin
                    int n;
                    n = 0;
                    for (int dr = -1; dr <= 1; dr++)
                        for (int dc = -1; dc <= 1; dc++)
                            if (!(dr == 0 && dc == 0) && r+dr >= 0 && r+dr < 10 &&
                                c+dc >= 0 && c+dc < 10 && g[(r+dr)*10+c+dc])
                                n++;
                    if (n < 4) m[r*10+c] = 1'b1;
                end
            end
        end
        return m;
    endfunction

    always @(posedge clk) begin
        if (s_we) grid[s_addr] <= s_wd;
        if (s_clr) begin
            sdone <= 1'b0;
            srem  <= '0;
            lat   <= 0;
        end else if (s_st) begin
            lat <= 4;
        end else if (lat == 1 && !hang) begin
            sdone <= 1'b1;
            srem  <= 16'($countones(removable(grid)));
            grid  <= grid & ~removable(grid);
            lat   <= 0;
        end else if (lat > 1) begin
            lat <= lat - 1;
        end
    end

    // Write-order and pass-structure monitors
    int wr_n = 0, wr_bad = 0, wr_base = 0, starts = 0, clears = 0;
    always @(posedge clk) begin
        if (s_we) begin
            if (int'(s_addr) != wr_n - wr_base) wr_bad <= wr_bad + 1;
            wr_n <= wr_n + 1;
        end
        if (st1) starts <= starts + 1;
        if (clr1 && busy1 && !rdy1) clears <= clears + 1;
    end

    int total = 0, bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_go(input bit which);
        @(negedge clk);
        if (which) go2 = 1'b1; else go1 = 1'b1;
        @(negedge clk);
        go1 = 1'b0;
        go2 = 1'b0;
    endtask

    task automatic load_grid(input logic [99:0] pat, input bit toggle);
        int idx = 0;
        int g = 0;
        int bad0;
        bit rdy;
        wr_base = wr_n;
        bad0 = wr_bad;
        while (idx < 100 && g < 400) begin
            rdy = sel ? rdy2 : rdy1;
            lv = toggle ? (g % 3 != 1) : 1'b1;
            ld = pat[idx];
            @(negedge clk);
            if (lv && rdy) idx++;
            g++;
        end
        lv = 1'b0;
        ld = 1'b0;
        check("cells_accepted", idx, 100);
        check("writes_seen", wr_n - wr_base, 100);
        check("write_addr_errors", wr_bad - bad0, 0);
    endtask

    task automatic wait_done(input bit which, input int budget);
        int n = 0;
        while (!(which ? done2 : done1) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_reached", which ? done2 : done1, 1);
    endtask

    task automatic run(input logic [99:0] pat, input bit toggle);
        pulse_go(1'b0);
        load_grid(pat, toggle);
        wait_done(1'b0, 200);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_clear"}, clr1, 1);
        check({tag, "_busy"}, busy1, 0);
        check({tag, "_done"}, done1, 0);
        check({tag, "_start"}, st1, 0);
        check({tag, "_ready"}, rdy1, 0);
        check({tag, "_we"}, we1, 0);
        check({tag, "_addr"}, addr1, 0);
        check({tag, "_total"}, tot1, 0);
        check({tag, "_pass"}, pc1, 0);
        check({tag, "_limit"}, lim1, 0);
        check({tag, "_timeout"}, tmo1, 0);
    endtask

    logic [99:0] pat;
    int s0, c0, n;

    initial begin
        rst_n = 1'b0; go1 = 1'b0; go2 = 1'b0; lv = 1'b0; ld = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("rst");
        rst_n = 1'b1;

        // Empty grid: a single pass that removes nothing
        run('0, 1'b0);
        check("t1_total", tot1, 0);
        check("t1_pass", pc1, 1);
        check("t1_limit", lim1, 0);
        check("t1_timeout", tmo1, 0);
        check("t1_busy", busy1, 0);

        // Isolated roll: removed on pass 1, pass 2 is stable
        pat = '0; pat[55] = 1'b1;
        run(pat, 1'b0);
        check("t2_total", tot1, 1);
        check("t2_pass", pc1, 2);

        // 2x2 block: each roll has 3 neighbours, all four go on pass 1
        pat = '0; pat[0] = 1'b1; pat[1] = 1'b1; pat[10] = 1'b1; pat[11] = 1'b1;
        s0 = starts; c0 = clears;
        run(pat, 1'b0);
        check("t3_total", tot1, 4);
        check("t3_pass", pc1, 2);
        check("t3_starts", starts - s0, 2);
        check("t3_clear_cycles", clears - c0, 2);

        // MAX_PASSES=1 build stops on the pass limit
        sel = 1'b1;
        pat = '0; pat[55] = 1'b1;
        pulse_go(1'b1);
        load_grid(pat, 1'b0);
        wait_done(1'b1, 200);
        check("t4_limit", lim2, 1);
        check("t4_total", tot2, 1);
        check("t4_pass", pc2, 1);
        check("t4_timeout", tmo2, 0);
        sel = 1'b0;

        // Hung solver: WAIT occupies TMO cycles, timeout shows on the following cycle
        hang = 1'b1;
        pat = '0; pat[55] = 1'b1;
        pulse_go(1'b0);
        load_grid(pat, 1'b0);
        n = 0;
        while (!st1 && n < 20) begin @(negedge clk); n++; end
        check("t5_start_seen", st1, 1);
        n = 0;
        while (!tmo1 && n < TMO + 50) begin @(negedge clk); n++; end
        check("t5_timeout_delay", n, TMO + 1);
        check("t5_timeout", tmo1, 1);
        check("t5_done", done1, 1);
        check("t5_pass", pc1, 0);
        check("t5_total", tot1, 0);
        check("t5_limit", lim1, 0);

        // Stalled load, then reset while waiting on the solver
        pat = '0; pat[0] = 1'b1; pat[1] = 1'b1; pat[10] = 1'b1; pat[11] = 1'b1;
        pulse_go(1'b0);
        load_grid(pat, 1'b1);
        repeat (6) @(negedge clk);
        check("t6_busy_in_wait", busy1, 1);
        rst_n = 1'b0;
        #1;
        check_reset("t6_rst");
        @(negedge clk);
        rst_n = 1'b1;
        hang = 1'b0;
        pat = '0; pat[55] = 1'b1;
        run(pat, 1'b1);
        check("t6_total", tot1, 1);
        check("t6_pass", pc1, 2);
        check("t6_timeout", tmo1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pass_scheduler.md
Name: pass_scheduler

Overview:
Sequences the grid solver core for the iterate-until-stable variant of the roll-removal puzzle. It streams the grid into the core's cell memory, then runs repeated solver passes: it clears the core, starts it, waits for done and adds the pass result. It stops when a pass removes nothing, when the pass limit is reached, or when a pass times out. The block sits between the host loader and the solver core and owns the core's clear, start and write ports.

Parameters:
GRID_CELLS, 100, number of cells streamed per load (10x10 grid)
ADDR_W, 7, width of the solver write address
REM_W, 16, width of the solver per-pass removed count
TOTAL_W, 24, width of the accumulated grand total
PASS_W, 8, width of the pass counter
MAX_PASSES, 255, pass limit; must be at least 1
TIMEOUT, 1023, maximum cycles spent in WAIT per pass

Ports:
clocking$clock  in  1  clock
clocking$clear_n  in  1  asynchronous active-low reset
go  in  1  one-cycle pulse; begins load and solve; honoured only in IDLE or FINISH
load_valid  in  1  host cell valid
load_data  in  1  host cell value (1 = roll present)
load_ready  out  1  block accepts a cell
solver_clear  out  1  synchronous clear to the solver core
solver_start  out  1  start pulse to the solver core
solver_write_enable  out  1  cell memory write strobe
solver_write_address  out  ADDR_W  cell index
solver_write_data  out  1  cell value
solver_done  in  1  solver core done flag (level)
solver_removed  in  REM_W  solver core per-pass removed count
busy  out  1  high in every state except IDLE and FINISH
done_  out  1  high in FINISH
grand_total  out  TOTAL_W  sum of all pass results; saturates at the maximum value
pass_count  out  PASS_W  number of completed passes
limit_hit  out  1  run ended because MAX_PASSES was reached
timeout  out  1  run ended because a pass timed out

Behaviour:
- Reset is asynchronous on clocking$clear_n low.
  - State resets to IDLE; address, wait counter, grand_total, pass_count, limit_hit and timeout reset to 0.
  - solver_clear reads 1 in reset; all other outputs read 0.
- All outputs are decoded from registers and have no combinational path from inputs. Exceptions: solver_write_enable = load_valid & load_ready; solver_write_data = load_data.
- solver_clear is 1 in IDLE, LOAD, CLEAR and FINISH, and 0 in START, WAIT and ACCUM.
- IDLE: load_ready = 0. On go, load the address with 0 and clear grand_total, pass_count, limit_hit and timeout, then go to LOAD.
- LOAD: load_ready = 1.
  - Each accepted cell writes at solver_write_address, then the address increments.
  - When the cell at address GRID_CELLS-1 is accepted, go to CLEAR.
  - load_valid low stalls with no timeout.
- CLEAR: lasts one cycle, then go to START.
- START: solver_start = 1 for exactly one cycle; zero the wait counter; go to WAIT.
- WAIT:
  - The wait counter increments each cycle.
  - If solver_done = 1, capture solver_removed into a register and go to ACCUM.
  - Otherwise, when the wait counter reaches TIMEOUT, set timeout = 1 and go to FINISH.
  - If solver_done and the timeout condition occur in the same cycle, solver_done wins.
- ACCUM: lasts one cycle.
  - grand_total += captured value; the sum saturates and does not wrap.
  - pass_count increments and saturates.
  - If the captured value is 0, go to FINISH.
  - Otherwise, if the new pass_count equals MAX_PASSES, set limit_hit = 1 and go to FINISH.
  - Otherwise, go to CLEAR.
- FINISH:
  - done_ = 1; results hold stable.
  - go restarts exactly as from IDLE; the grid is re-streamed.
- go is ignored while busy. load_valid is ignored outside LOAD.
- The solver core's cell memory survives solver_clear, so the grid state carries across passes. The capture in WAIT must happen before the next CLEAR, because clear zeroes the core's count.
- Latency per pass is CLEAR + START + solver time + ACCUM, i.e. solver time + 3 cycles.

Test Plan:
1. Reset, then go, then stream 100 zero cells → one pass; done_=1, grand_total=0, pass_count=1, limit_hit=0, timeout=0.
2. Stream a single roll at cell 55 → pass 1 removes 1 and pass 2 removes 0; grand_total=1, pass_count=2.
3. Stream a 2x2 block at cells 0, 1, 10 and 11 → grand_total=4, pass_count=2. Check that solver_start pulses exactly twice and that solver_clear is high for exactly one cycle between passes.
4. Build with MAX_PASSES=1 and a single roll → FINISH after pass 1 with limit_hit=1, grand_total=1, pass_count=1.
5. Use a stub solver that never raises done → timeout=1 exactly TIMEOUT cycles after START, done_=1, pass_count=0.
6. Toggle load_valid during LOAD and pull clocking$clear_n low mid-WAIT → correct addresses with no skipped or duplicated writes. On reset: state IDLE, every output 0 except solver_clear=1, and go accepted again afterwards.
